// File: rtl/video_timing.sv
// -----------------------------------------------------------------------------
// video_timing
//   Raster timing generator. A free-running 2-bit divider produces a pixel
//   enable (clk_sys/4 or clk_sys/2). Each pixel advances hcount. Each line
//   wrap advances vcount. Sync, blank, display-enable, border and interrupt
//   are decoded from the next counter values and registered, so they change
//   on the same clk_sys edge as the counters.
//
// Ports
//   clk_sys     in   master clock (single domain)
//   reset       in   synchronous, active-high
//   ce_divider  in   0: pixel rate clk_sys/4, 1: clk_sys/2
//   ce_pix      out  one-clk_sys pixel enable strobe
//   hcount      out  [8:0] pixel in line, 0..H_TOTAL-1
//   vcount      out  [8:0] line in frame, 0..V_TOTAL-1
//   HSync/VSync out  active-low syncs
//   hblank/vblank out active-high blanking
//   de          out  high inside the 256x192 paper area
//   border      out  high outside paper but not blanked
//   int_n       out  active-low frame interrupt
//   frame_start out  one-cycle pulse when the counters wrap to (0,0)
// -----------------------------------------------------------------------------
module video_timing #(
  parameter int H_TOTAL  = 448,
  parameter int V_TOTAL  = 312,
  parameter int HS_START = 344,
  parameter int HS_END   = 375,
  parameter int HB_START = 320,
  parameter int HB_END   = 415,
  parameter int VS_START = 248,
  parameter int VS_END   = 251,
  parameter int VB_START = 248,
  parameter int VB_END   = 255,
  parameter int INT_LEN  = 64
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_divider,
  output logic       ce_pix,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       HSync,
  output logic       VSync,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic       border,
  output logic       int_n,
  output logic       frame_start
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] HS_S   = 9'(HS_START);
  localparam logic [8:0] HS_E   = 9'(HS_END);
  localparam logic [8:0] HB_S   = 9'(HB_START);
  localparam logic [8:0] HB_E   = 9'(HB_END);
  localparam logic [8:0] VS_S   = 9'(VS_START);
  localparam logic [8:0] VS_E   = 9'(VS_END);
  localparam logic [8:0] VB_S   = 9'(VB_START);
  localparam logic [8:0] VB_E   = 9'(VB_END);
  localparam logic [8:0] INT_L  = 9'(INT_LEN);

  logic [1:0] div_q, div_d;
  logic       ce_pix_q, ce_pix_d;
  logic [8:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       de_q, de_d;
  logic       border_q, border_d;
  logic       int_n_q, int_n_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, v_wrap;

  always_comb begin
    div_d = div_q + 2'd1;
    // The strobe is decoded from the next divider value and registered, so
    // ce_pix is high in the cycle where div==3 (/4) or div[0]==1 (/2), and a
    // ce_divider change is seen from the following cycle onward.
    ce_pix_d = ce_divider ? div_d[0] : (div_d == 2'd3);

    h_wrap = (hcount_q == H_LAST);
    v_wrap = (vcount_q == V_LAST);

    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (ce_pix_q) begin
      if (h_wrap) begin
        hcount_d = 9'd0;
        vcount_d = v_wrap ? 9'd0 : vcount_q + 9'd1;
      end else begin
        hcount_d = hcount_q + 9'd1;
      end
    end
    frame_start_d = ce_pix_q && h_wrap && v_wrap;

    // Decoding the next counter values keeps the decoded outputs aligned to
    // the counters; without a pixel enable next == current, so they hold.
    hsync_d  = !((hcount_d >= HS_S) && (hcount_d <= HS_E));
    vsync_d  = !((vcount_d >= VS_S) && (vcount_d <= VS_E));
    hblank_d = (hcount_d >= HB_S) && (hcount_d <= HB_E);
    vblank_d = (vcount_d >= VB_S) && (vcount_d <= VB_E);
    de_d     = (hcount_d < 9'd256) && (vcount_d < 9'd192);
    border_d = !de_d && !(hblank_d || vblank_d);
    int_n_d  = !((vcount_d == VS_S) && (hcount_d < INT_L));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q         <= 2'd0;
      ce_pix_q      <= 1'b0;
      hcount_q      <= 9'd0;
      vcount_q      <= 9'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      de_q          <= 1'b1;
      border_q      <= 1'b0;
      int_n_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      ce_pix_q      <= ce_pix_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      border_q      <= border_d;
      int_n_q       <= int_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ce_pix      = ce_pix_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign border      = border_q;
  assign int_n       = int_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// -----------------------------------------------------------------------------
// tb_video_timing
//   Directed bench. Instance "a" uses the default geometry and checks reset,
//   release latency, horizontal timing, border/de and the /4 -> /2 switch.
//   Instance "b" uses a tiny raster so whole frames fit in a short run and
//   checks vertical timing, int_n, frame_start period and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_video_timing;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_b, ce_div_a, ce_div_b;

  logic       ce_pix_a, hsync_a, vsync_a, hblank_a, vblank_a, de_a, border_a, int_n_a, fs_a;
  logic [8:0] hcount_a, vcount_a;
  logic       ce_pix_b, hsync_b, vsync_b, hblank_b, vblank_b, de_b, border_b, int_n_b, fs_b;
  logic [8:0] hcount_b, vcount_b;

  video_timing u_dut_a (
    .clk_sys(clk), .reset(rst_a), .ce_divider(ce_div_a),
    .ce_pix(ce_pix_a), .hcount(hcount_a), .vcount(vcount_a),
    .HSync(hsync_a), .VSync(vsync_a), .hblank(hblank_a), .vblank(vblank_a),
    .de(de_a), .border(border_a), .int_n(int_n_a), .frame_start(fs_a)
  );

  video_timing #(
    .H_TOTAL(16), .V_TOTAL(12),
    .HS_START(10), .HS_END(11), .HB_START(8), .HB_END(13),
    .VS_START(8), .VS_END(9), .VB_START(8), .VB_END(10),
    .INT_LEN(4)
  ) u_dut_b (
    .clk_sys(clk), .reset(rst_b), .ce_divider(ce_div_b),
    .ce_pix(ce_pix_b), .hcount(hcount_b), .vcount(vcount_b),
    .HSync(hsync_b), .VSync(vsync_b), .hblank(hblank_b), .vblank(vblank_b),
    .de(de_b), .border(border_b), .int_n(int_n_b), .frame_start(fs_b)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Conditions the bench can wait on.
  function automatic logic sig(input int sel);
    case (sel)
      0:  return hsync_a;
      1:  return hblank_a;
      2:  return ce_pix_a;
      3:  return vsync_b;
      4:  return int_n_b;
      5:  return vblank_b;
      6:  return fs_b;
      7:  return hcount_a == 9'd256;
      8:  return hcount_a == 9'd0;
      9:  return hcount_a == 9'd100;
      10: return (vcount_b == 9'd5) && (hcount_b == 9'd7);
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait at negedges; an expired bound is reported as a failure.
  task automatic wait_until(input string tag, input int sel, input logic val, input int bound);
    int n = 0;
    while (sig(sel) !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_reached"}, 32'(sig(sel) === val), 32'd1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int unsigned t0, t1;
  int fs_seen;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; ce_div_a = 1'b0; ce_div_b = 1'b1;
    step(3);

    // Reset state
    check_val("rst_hcount", 32'(hcount_a), 32'd0);
    check_val("rst_vcount", 32'(vcount_a), 32'd0);
    check_val("rst_ce_pix", 32'(ce_pix_a), 32'd0);
    check_val("rst_hsync",  32'(hsync_a),  32'd1);
    check_val("rst_vsync",  32'(vsync_a),  32'd1);
    check_val("rst_hblank", 32'(hblank_a), 32'd0);
    check_val("rst_vblank", 32'(vblank_a), 32'd0);
    check_val("rst_de",     32'(de_a),     32'd1);
    check_val("rst_border", 32'(border_a), 32'd0);
    check_val("rst_int_n",  32'(int_n_a),  32'd1);
    check_val("rst_fs",     32'(fs_a),     32'd0);
    check_val("rst_b_de",   32'(de_b),     32'd1);

    // Release: ce_pix on the 4th cycle, then every 4
    rst_a = 1'b0; rst_b = 1'b0;
    t0 = cyc;
    wait_until("first_ce", 2, 1'b1, 10);
    check_val("first_ce_lat", cyc - t0, 32'd3);
    check_val("first_ce_h",   32'(hcount_a), 32'd0);
    t0 = cyc;
    step(1);
    check_val("h_after_ce", 32'(hcount_a), 32'd1);
    check_val("ce_low",     32'(ce_pix_a), 32'd0);
    wait_until("second_ce", 2, 1'b1, 10);
    check_val("ce_period4", cyc - t0, 32'd4);

    // Horizontal decode on line 0
    wait_until("h256", 7, 1'b1, 2000);
    check_val("h256_de",     32'(de_a),     32'd0);
    check_val("h256_border", 32'(border_a), 32'd1);
    check_val("h256_hblank", 32'(hblank_a), 32'd0);
    wait_until("hb_rise", 1, 1'b1, 2000);
    check_val("hb_rise_h",   32'(hcount_a), 32'd320);
    check_val("hb_border",   32'(border_a), 32'd0);
    wait_until("hs_fall", 0, 1'b0, 2000);
    check_val("hs_fall_h",   32'(hcount_a), 32'd344);
    t1 = cyc;
    wait_until("hs_rise", 0, 1'b1, 2000);
    check_val("hs_rise_h",   32'(hcount_a), 32'd376);
    check_val("hs_width4",   cyc - t1, 32'd128);
    wait_until("hb_fall", 1, 1'b0, 2000);
    check_val("hb_fall_h",   32'(hcount_a), 32'd416);
    wait_until("line_wrap", 8, 1'b1, 2000);
    check_val("wrap_vcount", 32'(vcount_a), 32'd1);
    check_val("wrap_de",     32'(de_a),     32'd1);
    check_val("wrap_border", 32'(border_a), 32'd0);
    wait_until("hs_fall2", 0, 1'b0, 4000);
    check_val("hs_period4",  cyc - t1, 32'd1792);

    // Switch to /2 mid-line: no skipped or repeated pixels
    wait_until("h100", 9, 1'b1, 4000);
    check_val("h100_v", 32'(vcount_a), 32'd2);
    ce_div_a = 1'b1;
    step(20);
    check_val("h_after_sw", 32'(hcount_a), 32'd110);
    wait_until("ce2_a", 2, 1'b1, 10);
    t0 = cyc;
    step(1);
    wait_until("ce2_b", 2, 1'b1, 10);
    check_val("ce_period2", cyc - t0, 32'd2);
    wait_until("hs_fall3", 0, 1'b0, 4000);
    t1 = cyc;
    wait_until("hs_rise3", 0, 1'b1, 4000);
    check_val("hs_width2", cyc - t1, 32'd64);
    wait_until("hs_fall4", 0, 1'b0, 4000);
    check_val("hs_period2", cyc - t1, 32'd896);

    // Small raster: vertical timing, int_n, frame_start
    wait_until("vs_hi_b", 3, 1'b1, 2000);
    wait_until("vs_fall_b", 3, 1'b0, 2000);
    check_val("vs_fall_v",   32'(vcount_b), 32'd8);
    check_val("vs_fall_h",   32'(hcount_b), 32'd0);
    check_val("vs_int_n",    32'(int_n_b),  32'd0);
    check_val("vs_vblank",   32'(vblank_b), 32'd1);
    t1 = cyc;
    wait_until("int_rise_b", 4, 1'b1, 2000);
    check_val("int_rise_h",  32'(hcount_b), 32'd4);
    check_val("int_width",   cyc - t1, 32'd8);
    wait_until("vs_rise_b", 3, 1'b1, 2000);
    check_val("vs_rise_v",   32'(vcount_b), 32'd10);
    check_val("vs_width",    cyc - t1, 32'd64);
    wait_until("vb_fall_b", 5, 1'b0, 2000);
    check_val("vb_fall_v",   32'(vcount_b), 32'd11);
    check_val("vb_fall_h",   32'(hcount_b), 32'd0);
    wait_until("fs_b1", 6, 1'b1, 2000);
    check_val("fs_h", 32'(hcount_b), 32'd0);
    check_val("fs_v", 32'(vcount_b), 32'd0);
    t1 = cyc;
    step(1);
    check_val("fs_one_cycle", 32'(fs_b), 32'd0);
    wait_until("fs_b2", 6, 1'b1, 2000);
    check_val("fs_period", cyc - t1, 32'd384);

    // Mid-frame reset: restart at (0,0) without a frame_start pulse
    wait_until("mid_frame", 10, 1'b1, 2000);
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    check_val("mrst_h",     32'(hcount_b), 32'd0);
    check_val("mrst_v",     32'(vcount_b), 32'd0);
    check_val("mrst_de",    32'(de_b),     32'd1);
    check_val("mrst_hsync", 32'(hsync_b),  32'd1);
    check_val("mrst_vsync", 32'(vsync_b),  32'd1);
    check_val("mrst_fs",    32'(fs_b),     32'd0);
    fs_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (fs_b) fs_seen++;
    end
    check_val("mrst_no_fs", 32'(fs_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL expose parameter H_TOTAL, default 448, pixels per line.
REQ-002 SHALL expose parameter V_TOTAL, default 312, lines per frame.
REQ-003 SHALL expose parameters HS_START/HS_END, defaults 344/375, HSync low window in pixels, inclusive.
REQ-004 SHALL expose parameters HB_START/HB_END, defaults 320/415, horizontal blank window, inclusive.
REQ-005 SHALL expose parameters VS_START/VS_END, defaults 248/251, VSync low window in lines, inclusive.
REQ-006 SHALL expose parameters VB_START/VB_END, defaults 248/255, vertical blank window, inclusive.
REQ-007 SHALL expose parameter INT_LEN, default 64, int_n low length in pixels.
REQ-008 clk_sys  input  1  master clock; one clock domain only.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 ce_divider  input  1  0 = pixel rate clk_sys/4, 1 = clk_sys/2.
REQ-011 ce_pix  output  1  one-clk_sys pixel enable strobe.
REQ-012 hcount  output  9  pixel position in line, 0..H_TOTAL-1.
REQ-013 vcount  output  9  line position in frame, 0..V_TOTAL-1.
REQ-014 HSync, VSync  output  1 each  active-low syncs, idle high.
REQ-015 hblank, vblank  output  1 each  active-high blanking.
REQ-016 de  output  1  high inside the 256x192 paper area (hcount<256 and vcount<192).
REQ-017 border  output  1  high when not de and not (hblank or vblank).
REQ-018 int_n  output  1  active-low frame interrupt.
REQ-019 frame_start  output  1  one-clk_sys pulse on wrap to (0,0).

Function
REQ-020 2-bit divider div SHALL increment every clk_sys cycle, free-running, wrapping 3->0.
REQ-021 ce_divider=0: ce_pix SHALL be high exactly when div==3; ce_divider=1: ce_pix SHALL be high when div[0]==1.
REQ-022 ce_divider change SHALL take effect in the next cycle without resetting div or the counters.
REQ-023 On a cycle with ce_pix high, hcount SHALL increment; hcount==H_TOTAL-1 SHALL wrap it to 0 and advance vcount.
REQ-024 vcount==V_TOTAL-1 at an hcount wrap SHALL wrap vcount to 0.
REQ-025 Without ce_pix, counters and all decoded outputs SHALL hold.
REQ-026 HSync, VSync, hblank, vblank, de, border and int_n SHALL be registered and decoded from the next counter values, so they change in the same cycle as hcount/vcount (zero skew to counters).
REQ-027 HSync SHALL be low iff HS_START<=hcount<=HS_END; VSync SHALL be low iff VS_START<=vcount<=VS_END.
REQ-028 hblank/vblank SHALL follow the HB/VB windows likewise.
REQ-029 int_n SHALL be low iff vcount==VS_START and hcount<INT_LEN.
REQ-030 frame_start SHALL pulse high for exactly the one clk_sys cycle in which the counters become (0,0) via wrap, not via reset.
REQ-031 All window comparisons SHALL be unsigned 9-bit; parameters SHALL satisfy START<=END<TOTAL; windows SHALL NOT wrap across 0.

Reset
REQ-032 Reset SHALL force div=0, hcount=0, vcount=0, ce_pix=0, HSync=1, VSync=1, hblank=0, vblank=0, de=1, border=0, int_n=1, frame_start=0.
REQ-033 Reset SHALL take priority over ce_pix in the same cycle; asserted mid-frame, it SHALL restart timing at (0,0) in the next cycle.

Verification
REQ-034 Release reset with ce_divider=0 -> ce_pix first high on the 4th cycle after release (div==3), then every 4 cycles; hcount=1 thereafter.
REQ-035 ce_divider=0, free run -> HSync period 1792 clk_sys, low 128 clk_sys; frame_start period 559104 clk_sys.
REQ-036 Free run -> VSync low for lines 248..251 (4 lines), vblank for lines 248..255, de high only for hcount 0..255 at vcount 0..191.
REQ-037 Free run -> int_n low for 64 pixels (256 clk_sys at /4) starting at hcount 0 of line 248, once per frame.
REQ-038 ce_divider switched 0->1 mid-line -> ce_pix every 2 clk_sys, no hcount skip or repeat, line period becomes 896 clk_sys.
REQ-039 Reset pulsed at hcount=300, vcount=200 -> next cycle hcount=0, vcount=0, de=1, HSync=1, VSync=1, no frame_start pulse.
